// File: rtl/otsu_binarizador.sv
// Per-pixel binarizer downstream of the Otsu threshold block: holds a per-frame
// threshold updated at VS fall and counts foreground pixels per frame.
module otsu_binarizador #(
    parameter int PIX_W        = 8,
    parameter int CNT_W        = 19,
    parameter int SMOOTH_SHIFT = 2,
    parameter int INVERT       = 0,
    parameter int INIT_LEVEL   = 128
) (
    input  logic             iClk,
    input  logic             reset,
    input  logic             VS,
    input  logic             VGA_Read,
    input  logic [PIX_W-1:0] Valor_Pixel,
    input  logic [PIX_W-1:0] Level,
    output logic [PIX_W-1:0] oPixel,
    output logic             oValid,
    output logic [PIX_W-1:0] Limiar_Atual,
    output logic [CNT_W-1:0] Contagem_Frente,
    output logic             frame_done
);

    logic                    vs_q, vs_d;
    logic [PIX_W-1:0]        p1_q, p1_d;
    logic [1:0]              vld_pipe_q, vld_pipe_d;
    logic [PIX_W-1:0]        pix_q, pix_d;
    logic [PIX_W-1:0]        thr_q, thr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        cont_q, cont_d;
    logic                    fd_q, fd_d;

    logic                    vs_fall, fg, out_fg, inc;
    logic signed [PIX_W+1:0] diff, step, thr_sum;
    logic [PIX_W-1:0]        thr_next;
    logic [CNT_W-1:0]        cnt_inc;

    always_comb begin
        vs_fall  = vs_q & ~VS;
        fg       = p1_q > thr_q;
        out_fg   = fg ^ (INVERT != 0);
        inc      = vld_pipe_q[0] & fg;

        // Two guard bits keep Level - thr and the running sum exact in signed form.
        diff     = $signed({2'b00, Level}) - $signed({2'b00, thr_q});
        step     = diff >>> SMOOTH_SHIFT;
        thr_sum  = $signed({2'b00, thr_q}) + step;
        thr_next = (SMOOTH_SHIFT == 0) ? Level : PIX_W'(thr_sum);

        cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(inc);

        vs_d       = VS;
        p1_d       = Valor_Pixel;
        vld_pipe_d = {vld_pipe_q[0], VGA_Read};
        pix_d      = pix_q;
        thr_d      = thr_q;
        cnt_d      = cnt_inc;
        cont_d     = cont_q;
        fd_d       = vs_fall;

        if (vld_pipe_q[0])
            pix_d = out_fg ? '1 : '0;

        // The stage-2 pixel in the boundary cycle still belongs to the closing frame.
        if (vs_fall) begin
            thr_d  = thr_next;
            cont_d = cnt_inc;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge iClk) begin
        if (reset) begin
            vs_q       <= 1'b0;
            p1_q       <= '0;
            vld_pipe_q <= '0;
            pix_q      <= '0;
            thr_q      <= PIX_W'(INIT_LEVEL);
            cnt_q      <= '0;
            cont_q     <= '0;
            fd_q       <= 1'b0;
        end else begin
            vs_q       <= vs_d;
            p1_q       <= p1_d;
            vld_pipe_q <= vld_pipe_d;
            pix_q      <= pix_d;
            thr_q      <= thr_d;
            cnt_q      <= cnt_d;
            cont_q     <= cont_d;
            fd_q       <= fd_d;
        end
    end

    assign oPixel          = pix_q;
    assign oValid          = vld_pipe_q[1];
    assign Limiar_Atual    = thr_q;
    assign Contagem_Frente = cont_q;
    assign frame_done      = fd_q;

endmodule

// File: tb/tb_otsu_binarizador.sv
// Scoreboard bench: three configurations (smoothed, direct load, saturating+inverted)
// share one stimulus stream; expectations are queued at drive time.
module tb_otsu_binarizador;

    logic       clk = 1'b0;
    logic       reset, VS, VGA_Read;
    logic [7:0] Valor_Pixel, Level;

    logic [7:0]  op  [3];
    logic        ov  [3];
    logic [7:0]  lim [3];
    logic        fd  [3];
    logic [18:0] c0, c1;
    logic [3:0]  c2;

    localparam int SH   [3] = '{2, 0, 2};
    localparam int INV  [3] = '{0, 0, 1};
    localparam int MAXC [3] = '{524287, 524287, 15};

    otsu_binarizador dut0 (.iClk(clk), .reset(reset), .VS(VS), .VGA_Read(VGA_Read),
        .Valor_Pixel(Valor_Pixel), .Level(Level), .oPixel(op[0]), .oValid(ov[0]),
        .Limiar_Atual(lim[0]), .Contagem_Frente(c0), .frame_done(fd[0]));
    otsu_binarizador #(.SMOOTH_SHIFT(0)) dut1 (.iClk(clk), .reset(reset), .VS(VS),
        .VGA_Read(VGA_Read), .Valor_Pixel(Valor_Pixel), .Level(Level), .oPixel(op[1]),
        .oValid(ov[1]), .Limiar_Atual(lim[1]), .Contagem_Frente(c1), .frame_done(fd[1]));
    otsu_binarizador #(.CNT_W(4), .INVERT(1)) dut2 (.iClk(clk), .reset(reset), .VS(VS),
        .VGA_Read(VGA_Read), .Valor_Pixel(Valor_Pixel), .Level(Level), .oPixel(op[2]),
        .oValid(ov[2]), .Limiar_Atual(lim[2]), .Contagem_Frente(c2), .frame_done(fd[2]));

    always #5 clk = ~clk;

    typedef struct packed {
        int              due;
        logic [2:0][7:0] px;
    } pix_e;
    typedef struct packed {
        int               due;
        logic [2:0][31:0] cnt;
        logic [2:0][7:0]  thr;
    } frm_e;

    pix_e pq[$];
    frm_e fq[$];
    int   total = 0, bad = 0, cyc = 0;
    int   thr_m [3];
    int   cnt_m [3];
    bit   vs_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    function automatic int fdiv(input int x, input int sh);
        if (x >= 0) return x >> sh;
        return -((-x + (1 << sh) - 1) >> sh);
    endfunction

    function automatic int cnt_of(input int d);
        return (d == 0) ? int'(c0) : (d == 1) ? int'(c1) : int'(c2);
    endfunction

    task automatic step(input bit rs, input bit vs, input bit rd, input int px, input int lv);
        pix_e pe;
        frm_e fe;
        reset = rs; VS = vs; VGA_Read = rd; Valor_Pixel = 8'(px); Level = 8'(lv);
        if (rs) begin
            pq.delete(); fq.delete(); vs_m = 0;
            for (int d = 0; d < 3; d++) begin thr_m[d] = 128; cnt_m[d] = 0; end
        end else begin
            if (vs_m && !vs) begin
                fe.due = cyc + 1;
                for (int d = 0; d < 3; d++) begin
                    thr_m[d]  = (SH[d] == 0) ? lv : thr_m[d] + fdiv(lv - thr_m[d], SH[d]);
                    fe.cnt[d] = (cnt_m[d] > MAXC[d]) ? MAXC[d] : cnt_m[d];
                    fe.thr[d] = 8'(thr_m[d]);
                    cnt_m[d]  = 0;
                end
                fq.push_back(fe);
            end
            vs_m = vs;
            if (rd) begin
                pe.due = cyc + 2;
                for (int d = 0; d < 3; d++) begin
                    bit f;
                    f = px > thr_m[d];
                    if (f) cnt_m[d]++;
                    pe.px[d] = ((f ? 1 : 0) ^ INV[d]) ? 8'hFF : 8'h00;
                end
                pq.push_back(pe);
            end
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        pix_e pe;
        frm_e fe;
        if (ov[0] === 1'b1 || ov[1] === 1'b1 || ov[2] === 1'b1) begin
            if (pq.size() == 0) chk("pix_unexpected", 1, 0);
            else begin
                pe = pq.pop_front();
                chk("pix_latency", cyc, pe.due);
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("ovalid%0d", d), 32'(ov[d]), 1);
                    chk($sformatf("opixel%0d", d), 32'(op[d]), 32'(pe.px[d]));
                end
            end
        end
        if (fd[0] === 1'b1 || fd[1] === 1'b1 || fd[2] === 1'b1) begin
            if (fq.size() == 0) chk("frame_done_unexpected", 1, 0);
            else begin
                fe = fq.pop_front();
                chk("frame_due", cyc, fe.due);
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("frame_done%0d", d), 32'(fd[d]), 1);
                    chk($sformatf("contagem%0d", d), cnt_of(d), fe.cnt[d]);
                    chk($sformatf("limiar%0d", d), 32'(lim[d]), 32'(fe.thr[d]));
                end
            end
        end
    end

    initial begin
        // reset while pixels stream, VS low
        for (int i = 0; i < 3; i++) step(1, 0, 1, 200, 50);
        chk("rst_opixel", 32'(op[0]), 0);
        chk("rst_ovalid", 32'(ov[0]), 0);
        chk("rst_contagem", 32'(c0), 0);
        chk("rst_frame_done", 32'(fd[0]), 0);
        chk("rst_limiar", 32'(lim[0]), 128);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 10);
            chk("no_fd_after_rst", 32'(fd[0]), 0);
        end

        // basic binarize around thr=128
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 127, 0);
        step(0, 1, 1, 128, 0);
        step(0, 1, 1, 129, 0);
        step(0, 1, 1, 255, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 3, 0);
        chk("hold_opixel0", 32'(op[0]), 32'hFF);
        chk("hold_opixel2", 32'(op[2]), 32'h00);

        // mid-frame reset drops the partial count
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        // 1000 valid pixels, 300 above 128, with interleaved invalid cycles
        for (int i = 0; i < 1000; i++) begin
            if (i % 7 == 3) step(0, 1, 0, 255, 0);
            step(0, 1, 1, (i % 10 < 3) ? 129 + (i % 50) : (i % 129), 0);
        end
        step(0, 0, 0, 0, 200);
        chk("fd_pulse", 32'(fd[0]), 1);
        chk("cnt300", 32'(c0), 300);
        chk("cnt_sat", 32'(c2), 15);
        chk("lim_smooth1", 32'(lim[0]), 146);
        chk("lim_direct1", 32'(lim[1]), 200);
        step(0, 0, 0, 0, 0);
        chk("fd_one_cycle", 32'(fd[0]), 0);

        // empty frame
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("cnt_empty", 32'(c0), 0);
        chk("lim_smooth2", 32'(lim[0]), 109);
        chk("lim_direct2", 32'(lim[1]), 0);

        // back-to-back boundaries two cycles apart
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 77);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 33);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

        // edge collision: threshold moves 128 -> 250 while pixel 200 is in stage 2
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 200, 250);
        step(0, 0, 1, 200, 250);
        step(0, 0, 0, 0, 0);
        chk("collision_cnt", 32'(c1), 1);
        chk("collision_lim", 32'(lim[1]), 250);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

        chk("pix_queue_empty", pq.size(), 0);
        chk("frm_queue_empty", fq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
